unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported, word-organised, synchronous-read memory between the instruction-fetch port and the load/store data port of the core.
- Each cycle it arbitrates between the two requesters and drives the memory. It routes read data back one cycle later and exposes grants that the pipeline uses as stall conditions.
- Data accesses have priority. A starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 8, byte-address width of both requester ports.
- STARVE_MAX, 3, consecutive denied fetch-request cycles after which fetch wins the next conflict.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (one cycle after if_gnt)
- if_rdata  out  32  fetch data; meaningful only while if_rvalid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid (one cycle after d_gnt for loads only)
- d_rdata  out  32  load data; meaningful only while d_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W-2  word index = granted byte address[ADDR_W-1:2]
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0
- conflict_cnt  out  CNT_W  saturating count of cycles with if_req and d_req both high

Behaviour:
- Reset (async, rst=1):
  - if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we = 0.
  - mem_be, mem_addr, mem_wdata = 0.
  - starve_cnt = 0, conflict_cnt = 0, resp_owner = NONE.
  - Any in-flight read response is discarded: no rvalid pulses on the cycle after reset is released.
- Arbitration (combinational, every cycle out of reset):
  - Only d_req high: d_gnt = 1.
  - Only if_req high: if_gnt = 1.
  - Both high: d_gnt = 1 unless starve_cnt == STARVE_MAX, in which case if_gnt = 1.
  - Never both grants in one cycle. Neither request: no grant, mem_en = 0.
- Memory drive follows the winner in the grant cycle:
  - mem_en = 1.
  - mem_addr = winner address[ADDR_W-1:2]; bits [1:0] ignored.
  - Fetch: mem_we = 0, mem_be = 4'hF.
  - Data: mem_we = d_we, mem_be = d_we ? d_be : 4'hF, mem_wdata = d_wdata.
  - mem_wdata = 0 when the winner is fetch.
- Response routing:
  - resp_owner register ← IF on a fetch grant, ← D on a data-load grant, else ← NONE.
  - if_rvalid = (resp_owner == IF); d_rvalid = (resp_owner == D).
  - if_rdata = d_rdata = mem_rdata, passed through unregistered.
  - Stores produce no rvalid.
  - Back-to-back grants are allowed: one access issued and one response delivered per cycle, so throughput is 1 access/cycle.
- starve_cnt:
  - Resets to 0 on any if_gnt or when if_req = 0.
  - Increments on if_req & !if_gnt.
  - Saturates at STARVE_MAX.
- conflict_cnt: increments on if_req & d_req; saturates at 2^CNT_W-1 and holds.
- Simultaneous store-after-load to the same word in consecutive grants: the memory returns pre-write data for the load issued first. The arbiter applies no forwarding.

Test Plan:
- Reset mid-read: fetch if_addr=8'h10 granted, rst pulsed next edge → no if_rvalid; all outputs 0; conflict_cnt = 0.
- Fetch only: if_req=1, if_addr=8'h04 → same cycle if_gnt=1, mem_addr=1, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata (e.g. 32'h00402103).
- Store: d_req=1, d_we=1, d_addr=8'h0C, d_be=4'b0011, d_wdata=32'h0000000F → d_gnt=1, mem_we=1, mem_addr=3, mem_be=4'b0011; no d_rvalid afterwards.
- Conflict with starvation, STARVE_MAX=3: if_req and d_req (load) held high → d_gnt for 3 cycles, if_gnt on cycle 4, then d_gnt again; conflict_cnt = 4 after 4 cycles; rvalids alternate accordingly.
- Back-to-back: load granted cycle N, fetch granted cycle N+1 → d_rvalid at N+1, if_rvalid at N+2; never both rvalid high in one cycle.
- Saturation: CNT_W=4 with both requests held 20 cycles → conflict_cnt stops at 15.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported synchronous-read memory between
// instruction fetch and load/store. Data wins conflicts. Fetch wins once it
// has been refused STARVE_MAX consecutive cycles. Read data returns one cycle
// after the grant, and routing follows the recorded response owner.
//
// resp_owner | meaning
// -----------+--------------------------------------------------------
// OWN_NONE   | no read in flight; mem_rdata is ignored this cycle
// OWN_IF     | fetch read issued last cycle; mem_rdata goes to if_rdata
// OWN_D      | load issued last cycle; mem_rdata goes to d_rdata
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t        resp_owner, resp_owner_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          fetch_wins;

  // Byte-offset bits never reach the word-organised memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // Arbitration and memory drive. Everything stays quiet while reset is held.
  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_SAT));
    if (!rst) begin
      if (fetch_wins) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_be   = 4'hF;
        mem_addr = if_addr[ADDR_W-1:2];
      end else if (d_req) begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_be    = d_we ? d_be : 4'hF;
        mem_addr  = d_addr[ADDR_W-1:2];
        mem_wdata = d_wdata;
      end
    end
  end

  // Next response owner and next starvation count.
  always_comb begin
    resp_owner_nxt = OWN_NONE;
    if (if_gnt) begin
      resp_owner_nxt = OWN_IF;
    end else if (d_gnt && !d_we) begin
      resp_owner_nxt = OWN_D;
    end
    starve_nxt = starve_cnt;
    if (!if_req || if_gnt) begin
      starve_nxt = '0;
    end else if (starve_cnt != STARVE_SAT) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  // Registered state: response owner, starvation and conflict counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner   <= OWN_NONE;
      starve_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      resp_owner <= resp_owner_nxt;
      starve_cnt <= starve_nxt;
      if (if_req && d_req && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  assign if_rvalid = (resp_owner == OWN_IF);
  assign d_rvalid  = (resp_owner == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: memory emulator, abstract reference model,
// per-cycle comparator and directed scenarios with literal expectations.
module tb_unified_mem_arbiter;
  localparam int ADDR_W     = 8;
  localparam int STARVE_MAX = 3;
  localparam int CNT_W      = 4;
  localparam int WORDS      = 64;

  logic              clk, rst;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0]       if_rdata, d_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 1) return 32'h00402103;
    return 32'h10000000 | (i << 8) | i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory emulator: bus sampled mid-cycle, applied on the following edge.
  logic [31:0] mem [WORDS];
  initial begin
    logic            s_en, s_we;
    logic [3:0]      s_be;
    logic [5:0]      s_addr;
    logic [31:0]     s_wdata;
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      s_en = mem_en; s_we = mem_we; s_be = mem_be; s_addr = mem_addr; s_wdata = mem_wdata;
      @(posedge clk);
      if (s_en && s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_be[b]) mem[s_addr][b*8 +: 8] = s_wdata[b*8 +: 8];
        mem_rdata <= 32'hBAD0BAD0;
      end else if (s_en) begin
        mem_rdata <= mem[s_addr];
      end else begin
        mem_rdata <= 32'hBAD0BAD0;
      end
    end
  end

  // Reference model: refused-cycle count, conflict count, owner of the
  // pending response and a shadow of memory contents.
  int          m_starve, m_conf, m_resp;
  logic [31:0] m_data;
  logic [31:0] m_mem [WORDS];
  initial begin
    bit f_win, d_win;
    for (int i = 0; i < WORDS; i++) m_mem[i] = init_word(i);
    m_starve = 0; m_conf = 0; m_resp = 0; m_data = 32'h0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_starve = 0; m_conf = 0; m_resp = 0;
      end else begin
        f_win = if_req && (!d_req || m_starve >= STARVE_MAX);
        d_win = d_req && !f_win;
        if (if_req && d_req && m_conf < (1 << CNT_W) - 1) m_conf = m_conf + 1;
        if (!if_req || f_win) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
        if (f_win) begin
          m_resp = 1; m_data = m_mem[if_addr >> 2];
        end else if (d_win && !d_we) begin
          m_resp = 2; m_data = m_mem[d_addr >> 2];
        end else begin
          m_resp = 0;
        end
        if (d_win && d_we)
          for (int b = 0; b < 4; b++)
            if (d_be[b]) m_mem[d_addr >> 2][b*8 +: 8] = d_wdata[b*8 +: 8];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit          e_if, e_d, e_en, e_we;
    logic [3:0]  e_be;
    logic [5:0]  e_addr;
    logic [31:0] e_wdata;
    if (rst) begin
      chk("rst_outputs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}, 0);
      chk("rst_bus", {mem_be, mem_addr, mem_wdata[15:0]}, 0);
      chk("rst_wdata_conf", {mem_wdata, conflict_cnt} == 0, 1);
    end else begin
      e_if = if_req && (!d_req || m_starve >= STARVE_MAX);
      e_d  = d_req && !e_if;
      e_en = e_if || e_d;
      e_we = e_d && d_we;
      e_be = e_if ? 4'hF : (e_d ? (d_we ? d_be : 4'hF) : 4'h0);
      e_addr  = e_if ? if_addr[7:2] : (e_d ? d_addr[7:2] : 6'd0);
      e_wdata = e_d ? d_wdata : 32'h0;
      chk("if_gnt", if_gnt, e_if);
      chk("d_gnt", d_gnt, e_d);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_be", mem_be, e_be);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("if_rvalid", if_rvalid, m_resp == 1);
      chk("d_rvalid", d_rvalid, m_resp == 2);
      chk("conflict_cnt", conflict_cnt, m_conf);
      chk("rvalid_exclusive", if_rvalid && d_rvalid, 0);
      if (m_resp == 1) chk("if_rdata", if_rdata, m_data);
      if (m_resp == 2) chk("d_rdata", d_rdata, m_data);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset while a fetch read is in flight.
    if_req = 1; if_addr = 8'h10;
    @(negedge clk); chk("midread_gnt", if_gnt, 1);
    next_cycle(); rst = 1'b1; if_req = 0; if_addr = 0;
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("midread_no_rvalid", if_rvalid, 0);
    chk("midread_conf", conflict_cnt, 0);
    chk("midread_mem_en", mem_en, 0);

    // Fetch only.
    next_cycle(); if_req = 1; if_addr = 8'h04;
    @(negedge clk);
    chk("fetch_gnt", if_gnt, 1);
    chk("fetch_addr", mem_addr, 1);
    chk("fetch_we", mem_we, 0);
    next_cycle(); if_req = 0;
    @(negedge clk);
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'h00402103);

    // Partial store, then read the word back.
    next_cycle(); d_req = 1; d_we = 1; d_addr = 8'h0C; d_be = 4'b0011; d_wdata = 32'h0000000F;
    @(negedge clk);
    chk("store_gnt", d_gnt, 1);
    chk("store_we", mem_we, 1);
    chk("store_addr", mem_addr, 3);
    chk("store_be", mem_be, 4'b0011);
    next_cycle(); d_req = 0; d_we = 0;
    @(negedge clk); chk("store_no_rvalid", d_rvalid, 0);
    next_cycle(); d_req = 1; d_addr = 8'h0C;
    next_cycle(); d_req = 0;
    @(negedge clk);
    chk("store_readback", d_rdata, 32'h1000000F);

    // Back-to-back load then fetch.
    next_cycle(); d_req = 1; d_addr = 8'h14;
    next_cycle(); d_req = 0; if_req = 1; if_addr = 8'h18;
    @(negedge clk);
    chk("b2b_d_rvalid", d_rvalid, 1);
    chk("b2b_d_rdata", d_rdata, 32'h10000505);
    chk("b2b_if_gnt", if_gnt, 1);
    next_cycle(); if_req = 0;
    @(negedge clk);
    chk("b2b_if_rvalid", if_rvalid, 1);
    chk("b2b_d_rvalid_low", d_rvalid, 0);
    chk("b2b_if_rdata", if_rdata, 32'h10000606);

    // Load followed by a store to the same word: load sees pre-write data.
    next_cycle(); d_req = 1; d_we = 0; d_addr = 8'h20;
    next_cycle(); d_we = 1; d_be = 4'hF; d_wdata = 32'hAAAAAAAA;
    @(negedge clk);
    chk("raw_old_data", d_rdata, 32'h10000808);
    next_cycle(); d_we = 0;
    next_cycle(); d_req = 0;
    @(negedge clk);
    chk("raw_new_data", d_rdata, 32'hAAAAAAAA);

    // Sustained conflict: fetch wins every fourth cycle.
    next_cycle(); if_req = 1; if_addr = 8'h24; d_req = 1; d_we = 0; d_addr = 8'h28;
    pat = 8'b1000_1000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("starve_if_gnt", if_gnt, pat[k]);
      chk("starve_d_gnt", d_gnt, !pat[k]);
      if (k == 4) chk("conf_after_4", conflict_cnt, 4);
      next_cycle();
    end

    // Counter saturation.
    repeat (20) next_cycle();
    @(negedge clk); chk("conf_saturated", conflict_cnt, 15);
    next_cycle(); if_req = 0; d_req = 0;
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
